// File: rtl/arctan_pkg.sv
// Shared types and constants for the arctan datapath: divider FSM states,
// default operand widths, the multiplier scale constant and counter sizing.
package arctan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam int NUM_WIDTH_DEF = 21;
  localparam int DEN_WIDTH_DEF = 13;
  localparam int MUL_CONST     = 3547;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_WIDTH = cnt_width(NUM_WIDTH_DEF);

endpackage

// File: rtl/arctan_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract |den| when it fits and report the resulting quotient bit.
module arctan_div_step
  import arctan_pkg::*;
#(
  parameter int DEN_WIDTH = DEN_WIDTH_DEF
) (
  input  logic [DEN_WIDTH:0]   rem_in,
  input  logic                 din,
  input  logic [DEN_WIDTH-1:0] den_abs,
  output logic [DEN_WIDTH:0]   rem_out,
  output logic                 q_bit
);

  logic [DEN_WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_in[DEN_WIDTH-1:0], din};
    // a set bit shifted out of the top means the true value already exceeds |den|
    q_bit   = rem_in[DEN_WIDTH] | (shifted >= {1'b0, den_abs});
    rem_out = q_bit ? (shifted - {1'b0, den_abs}) : shifted;
  end

endmodule

// File: rtl/arctan_divider.sv
// Iterative signed divider, result NUM_WIDTH+1 cycles after accept; in_ready only in IDLE,
// inputs offered while busy are dropped and flag overrun. ARCTAN_DIV_ROUND_EN selects round-half-away.
module arctan_divider
  import arctan_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF,
  parameter int DEN_WIDTH = DEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NUM_WIDTH-1:0] numerator,
  input  logic [DEN_WIDTH-1:0] denominator,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [NUM_WIDTH-1:0] quot_out,
  output logic                 div_zero,
  output logic                 sat,
  output logic                 overrun
);

  localparam int CNT_W = cnt_width(NUM_WIDTH);
  localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(NUM_WIDTH - 1);
  localparam logic [NUM_WIDTH-1:0] POS_MAX  = {1'b0, {(NUM_WIDTH-1){1'b1}}};
  localparam logic [NUM_WIDTH-1:0] NEG_MIN  = {1'b1, {(NUM_WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic                 num_neg, den_neg, den_zero;
  logic [NUM_WIDTH-1:0] dvd;  // dividend leaves at the MSB, quotient enters at the LSB
  logic [DEN_WIDTH-1:0] den_abs;
  logic [DEN_WIDTH:0]   rem, rem_step;
  logic                 q_bit;
  logic [CNT_W-1:0]     cnt;

  logic [NUM_WIDTH-1:0] num_abs_in;
  logic [DEN_WIDTH-1:0] den_abs_in;
  logic                 rnd_up;
  logic [NUM_WIDTH:0]   mag;
  logic [NUM_WIDTH-1:0] res_q;
  logic                 res_sat;

  assign in_ready   = (state == ST_IDLE);
  assign num_abs_in = numerator[NUM_WIDTH-1] ? -numerator : numerator;
  assign den_abs_in = denominator[DEN_WIDTH-1] ? -denominator : denominator;

  arctan_div_step #(.DEN_WIDTH(DEN_WIDTH)) u_step (
    .rem_in  (rem),
    .din     (dvd[NUM_WIDTH-1]),
    .den_abs (den_abs),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  // a zero divisor still walks the counter so every result has the same latency
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
`ifdef ARCTAN_DIV_ROUND_EN
    rnd_up = ({rem, 1'b0} >= {2'b00, den_abs});
`else
    rnd_up = 1'b0;
`endif
    mag     = {1'b0, dvd} + {{NUM_WIDTH{1'b0}}, rnd_up};
    res_q   = '0;
    res_sat = 1'b0;
    if (den_zero) begin
      res_q = num_neg ? NEG_MIN : POS_MAX;
    end else if (num_neg ^ den_neg) begin
      if (mag > {1'b0, NEG_MIN}) begin
        res_q   = NEG_MIN;
        res_sat = 1'b1;
      end else begin
        res_q = -mag[NUM_WIDTH-1:0];
      end
    end else if (mag > {1'b0, POS_MAX}) begin
      res_q   = POS_MAX;
      res_sat = 1'b1;
    end else begin
      res_q = mag[NUM_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_neg   <= 1'b0;
      den_neg   <= 1'b0;
      den_zero  <= 1'b0;
      dvd       <= '0;
      den_abs   <= '0;
      rem       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      quot_out  <= '0;
      div_zero  <= 1'b0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: if (in_valid) begin
          num_neg  <= numerator[NUM_WIDTH-1];
          den_neg  <= denominator[DEN_WIDTH-1];
          den_zero <= (denominator == '0);
          dvd      <= num_abs_in;
          den_abs  <= den_abs_in;
          rem      <= '0;
          cnt      <= CNT_INIT;
        end
        ST_CALC: begin
          dvd <= {dvd[NUM_WIDTH-2:0], q_bit};
          rem <= rem_step;
          cnt <= cnt - CNT_W'(1);
        end
        ST_FIX: begin
          quot_out  <= res_q;
          div_zero  <= den_zero;
          sat       <= res_sat;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
